// File: rtl/cla_seq_pkg.sv
// Shared definitions for the multiword CLA sequencer.
package cla_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_e;

   // Slice index width; a single-slice configuration still keeps a 1-bit index.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/carry_look_ahead_adder.sv
// Combinational NUMBITS-wide carry-lookahead adder slice.
module carry_look_ahead_adder #(
   parameter int NUMBITS = 4
) (
   input  logic [NUMBITS-1:0] A,
   input  logic [NUMBITS-1:0] B,
   input  logic               carryin,
   output logic [NUMBITS-1:0] result,
   output logic               carryout
);

   logic [NUMBITS-1:0] gen;
   logic [NUMBITS-1:0] prop;
   logic [NUMBITS:0]   carry;

   assign gen  = A & B;
   assign prop = A ^ B;

   // Each carry is the flattened generate/propagate sum-of-products of all lower bits.
   always_comb begin
      logic cc;
      logic pp;
      carry    = '0;
      carry[0] = carryin;
      for (int i = 0; i < NUMBITS; i++) begin
         cc = gen[i];
         pp = prop[i];
         for (int j = i - 1; j >= 0; j--) begin
            cc = cc | (pp & gen[j]);
            pp = pp & prop[j];
         end
         cc = cc | (pp & carryin);
         carry[i+1] = cc;
      end
   end

   assign result   = prop ^ carry[NUMBITS-1:0];
   assign carryout = carry[NUMBITS];

endmodule

// File: rtl/cla_multiword_sequencer.sv
// Wide unsigned adder built from one shared CLA slice, LS slice first.
// state   | meaning
// IDLE    | waiting for operands, in_ready high
// RUN     | adding one slice per cycle, carry held between slices
// DONE    | result/carryout presented until consumer accepts
module cla_multiword_sequencer
   import cla_seq_pkg::*;
#(
   parameter int NUMBITS  = 4,
   parameter int NUMWORDS = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [NUMBITS*NUMWORDS-1:0]   A,
   input  logic [NUMBITS*NUMWORDS-1:0]   B,
   input  logic                          carryin,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [NUMBITS*NUMWORDS-1:0]   result,
   output logic                          carryout,
   output logic                          busy
);

   localparam int WIDTH = NUMBITS * NUMWORDS;
   localparam int IW    = idx_width(NUMWORDS);
   localparam logic [IW-1:0] LAST_IDX = IW'(NUMWORDS - 1);

   seq_state_e         state_q, state_d;
   logic [IW-1:0]      idx_q, idx_d;
   logic               carry_q, carry_d;
   logic [WIDTH-1:0]   a_q, a_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic [WIDTH-1:0]   result_q, result_d;
   logic               carryout_q, carryout_d;
   logic               out_valid_q, out_valid_d;

   logic [NUMBITS-1:0] a_slice;
   logic [NUMBITS-1:0] b_slice;
   logic [NUMBITS-1:0] sum_slice;
   logic               slice_co;

   // Select the operand slice addressed by the current index.
   always_comb begin
      a_slice = '0;
      b_slice = '0;
      for (int w = 0; w < NUMWORDS; w++) begin
         if (idx_q == IW'(w)) begin
            a_slice = a_q[w*NUMBITS +: NUMBITS];
            b_slice = b_q[w*NUMBITS +: NUMBITS];
         end
      end
   end

   carry_look_ahead_adder #(.NUMBITS(NUMBITS)) u_cla (
      .A        (a_slice),
      .B        (b_slice),
      .carryin  (carry_q),
      .result   (sum_slice),
      .carryout (slice_co)
   );

   // Sequencing: accept, walk slices, hold result until taken.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      carry_d     = carry_q;
      a_d         = a_q;
      b_d         = b_q;
      result_d    = result_q;
      carryout_d  = carryout_q;
      out_valid_d = out_valid_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               a_d      = A;
               b_d      = B;
               carry_d  = carryin;
               idx_d    = '0;
               result_d = '0;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            for (int w = 0; w < NUMWORDS; w++) begin
               if (idx_q == IW'(w)) begin
                  result_d[w*NUMBITS +: NUMBITS] = sum_slice;
               end
            end
            carry_d = slice_co;
            if (idx_q == LAST_IDX) begin
               carryout_d  = slice_co;
               out_valid_d = 1'b1;
               state_d     = ST_DONE;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and registered outputs; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         carry_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         result_q    <= '0;
         carryout_q  <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         carry_q     <= carry_d;
         a_q         <= a_d;
         b_q         <= b_d;
         result_q    <= result_d;
         carryout_q  <= carryout_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = reset && (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign carryout  = carryout_q;

endmodule

// File: doc/cla_multiword_sequencer.md
Name: cla_multiword_sequencer

Overview:
Sequencer that performs wide unsigned additions (WIDTH = NUMBITS*NUMWORDS) by reusing one NUMBITS-wide carry_look_ahead_adder over multiple cycles. Operates least-significant slice first and registers the carry between slices. Uses a valid/ready handshake on both input and output. Sits between operand producers and consumers wherever a full-width CLA costs too much area.

Parameters:
NUMBITS, 4, width of the shared carry_look_ahead_adder slice (>=1)
NUMWORDS, 4, number of slices per operation (>=1); WIDTH = NUMBITS*NUMWORDS

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  operand request
in_ready  output  1  block can accept operands
A  input  WIDTH  operand A, sampled on in_valid&&in_ready
B  input  WIDTH  operand B, sampled on in_valid&&in_ready
carryin  input  1  initial carry, sampled with A/B
out_valid  output  1  result/carryout valid
out_ready  input  1  consumer accepts result
result  output  WIDTH  sum (registered)
carryout  output  1  final carry out of MSB slice (registered)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (reset==0, async): state=IDLE, slice index=0, carry reg=0, A/B regs=0, result=0, carryout=0, out_valid=0, busy=0. in_ready forced 0 while reset is low.
- Any in-flight operation is discarded on reset; no partial result is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. On in_valid&&in_ready: capture A, B, carryin->carry reg; idx<=0; result<=0; go RUN.
- RUN: in_ready=0, busy=1. The adder slice input is A_reg[idx*NUMBITS +: NUMBITS], B_reg slice, carry reg. Each cycle: result[idx slice]<=adder result; carry reg<=adder carryout; idx<=idx+1.
- RUN exit: on the cycle idx==NUMWORDS-1, also carryout<=adder carryout and out_valid<=1, then go DONE. idx never exceeds NUMWORDS-1.
- Latency: accept at edge T -> out_valid high after edge T+NUMWORDS. NUMWORDS=1 gives a single RUN cycle.
- DONE: out_valid=1, busy=1, in_ready=0. result/carryout held stable until out_valid&&out_ready. On that edge: out_valid<=0, go IDLE. result/carryout retain their last value in IDLE.
- Input while not IDLE: ignored and not stalled internally. The producer must hold in_valid until in_ready.
- Throughput: one operation per NUMWORDS+2 cycles minimum. There is no accept in DONE.
- Arithmetic: unsigned modulo 2^WIDTH. carryout = bit WIDTH of A+B+carryin.
- idx register width: max(1, clog2(NUMWORDS)).

Decomposition:
- Shared package cla_seq_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2
  - index-width helper function
- Exactly one sub-module: an instance of the existing carry_look_ahead_adder #(.NUMBITS(NUMBITS)), purely combinational, driven from the slice mux.
- All sequencing lives in this module.

Test Plan:
- Reset: drive reset=0 mid-simulation -> result=0, carryout=0, out_valid=0, busy=0, in_ready=0. After release, in_ready=1 on the next sample.
- NUMBITS=4, NUMWORDS=4: A=16'hFFFF, B=16'h0001, carryin=0, out_ready=1 -> out_valid exactly 4 cycles after accept, result=16'h0000, carryout=1, then IDLE.
- A=16'h1234, B=16'h4321, carryin=1 -> result=16'h5556, carryout=0. in_ready=0 throughout RUN/DONE.
- Backpressure: A=16'h8000, B=16'h8000, out_ready=0 for 5 cycles -> result=16'h0000, carryout=1 held stable with out_valid=1. A second in_valid (A=16'h0001) during the hold is ignored. After the out_ready pulse, the block returns to IDLE.
- Reset mid-RUN: drop reset after 2 RUN cycles of 16'hFFFF+16'h0001 -> no out_valid. After release, A=16'h00FF, B=16'h0001 -> result=16'h0100, carryout=0.
- NUMBITS=4, NUMWORDS=1 instance: A=4'hF, B=4'h1 -> out_valid 1 cycle after accept, result=4'h0, carryout=1.
- NUMBITS=8, NUMWORDS=16 instance: all-ones + 1 -> result=0, carryout=1 after 16 cycles.
